clock_div_multi: RTL and testbench

Parametrised multi-channel clock/tick generator. Each of `N_CH` channels divides `clki` by its own runtime-programmable integer divisor and produces a near-50% duty square wave plus a one-cycle tick strobe per period. Divisor updates are glitch-free: a new value takes effect only at a period boundary. The block feeds display scan, key-scan and 1 Hz counting logic from the 50 MHz board clock.

---
 rtl/clock_div_multi.sv | 111 +++++++++++
 tb/tb_clock_div_multi.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_div_multi.sv
// Multi-channel programmable clock/tick divider with glitch-free divisor updates.
// Each channel counts clki cycles up to its active divisor and emits a tick strobe
// plus a near-50% square wave. New divisors are staged and applied at a period boundary.
module clock_div_multi #(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned CNT_W    = 27,
    parameter int unsigned DIV_INIT = 50000000
) (
    input  logic                                      clki,
    input  logic                                      rst,
    input  logic [N_CH-1:0]                           en,
    input  logic                                      sync,
    input  logic                                      div_wr,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] div_sel,
    input  logic [CNT_W-1:0]                          div_val,
    output logic                                      div_ack,
    output logic                                      div_err,
    output logic [N_CH-1:0]                           tick,
    output logic [N_CH-1:0]                           clk_out
);

    localparam int unsigned SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic sel_ok;
    logic val_ok;
    logic wr_ok;

    // A write is legal only for an existing channel and a divisor of at least 2.
    assign sel_ok = 32'(div_sel) < N_CH;
    assign val_ok = div_val >= CNT_W'(2);
    assign wr_ok  = div_wr && sel_ok && val_ok;

    // One-cycle write handshake, registered.
    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            div_ack <= 1'b0;
            div_err <= 1'b0;
        end else begin
            div_ack <= wr_ok;
            div_err <= div_wr && !(sel_ok && val_ok);
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] div_act;
        logic [CNT_W-1:0] div_pend;
        logic [CNT_W-1:0] half;
        logic             pend_v;
        logic             run;
        logic             start;
        logic             hit;
        logic             tick_r;
        logic             clk_r;

        // High phase length is ceil(div_act/2), computed without overflow.
        assign half  = (div_act >> 1) + CNT_W'(div_act[0]);
        // Period starts after a disable, at natural wrap, or on sync; all merge into one start.
        assign start = en[i] && (!run || (cnt == div_act - CNT_W'(1)) || sync);
        assign hit   = wr_ok && (div_sel == SEL_W'(i));

        assign tick[i]    = tick_r;
        assign clk_out[i] = clk_r;

        // Per-channel counter, divisor staging and registered outputs.
        always_ff @(posedge clki or posedge rst) begin
            if (rst) begin
                cnt      <= '0;
                div_act  <= CNT_W'(DIV_INIT);
                div_pend <= '0;
                pend_v   <= 1'b0;
                run      <= 1'b0;
                tick_r   <= 1'b0;
                clk_r    <= 1'b0;
            end else begin
                run    <= en[i];
                tick_r <= start;
                if (!en[i]) begin
                    // Stopped: flush any staged divisor, then a write goes straight in.
                    cnt   <= '0;
                    clk_r <= 1'b0;
                    if (pend_v) begin
                        div_act <= div_pend;
                        pend_v  <= 1'b0;
                    end
                    if (hit) begin
                        div_act <= div_val;
                    end
                end else begin
                    if (start) begin
                        cnt   <= '0;
                        clk_r <= 1'b1;
                        if (pend_v) begin
                            div_act <= div_pend;
                            pend_v  <= 1'b0;
                        end
                    end else begin
                        cnt   <= cnt + CNT_W'(1);
                        clk_r <= (cnt + CNT_W'(1)) < half;
                    end
                    // A write coinciding with a start is staged for the following boundary.
                    if (hit) begin
                        div_pend <= div_val;
                        pend_v   <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_clock_div_multi.sv
// Directed self-checking bench for clock_div_multi (3 channels, DIV_INIT=5).
`timescale 1ns/1ps
module tb_clock_div_multi;

    localparam int unsigned N_CH  = 3;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned DINIT = 5;

    logic             clki = 1'b0;
    logic             rst;
    logic [N_CH-1:0]  en;
    logic             sync;
    logic             div_wr;
    logic [1:0]       div_sel;
    logic [CNT_W-1:0] div_val;
    logic             div_ack;
    logic             div_err;
    logic [N_CH-1:0]  tick;
    logic [N_CH-1:0]  clk_out;

    int errors = 0;
    int checks = 0;

    clock_div_multi #(.N_CH(N_CH), .CNT_W(CNT_W), .DIV_INIT(DINIT)) dut (
        .clki(clki), .rst(rst), .en(en), .sync(sync),
        .div_wr(div_wr), .div_sel(div_sel), .div_val(div_val),
        .div_ack(div_ack), .div_err(div_err), .tick(tick), .clk_out(clk_out)
    );

    always #5 clki = ~clki;

    task automatic step();
        @(posedge clki);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = '0; sync = 1'b0; div_wr = 1'b0; div_sel = '0; div_val = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({tick, clk_out, div_ack, div_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 0", {tick, clk_out, div_ack, div_err});
        end
        step();
        checks++;
        if (tick !== '0 || clk_out !== '0) begin
            errors++;
            $display("FAIL disabled_idle: tick=%b clk_out=%b required 0", tick, clk_out);
        end
    endtask

    task automatic test_basic();
        do_reset();
        en = 3'b001;
        for (int k = 0; k < 10; k++) begin
            step();
            checks++;
            if (clk_out[0] !== ((k % 5) < 3) || tick[0] !== ((k % 5) == 0)) begin
                errors++;
                $display("FAIL basic_d5 k=%0d: clk=%b tick=%b required clk=%b tick=%b",
                         k, clk_out[0], tick[0], (k % 5) < 3, (k % 5) == 0);
            end
        end
    endtask

    task automatic test_div_write();
        do_reset();
        en = 3'b010;
        step();
        step();
        div_wr = 1'b1; div_sel = 2'd1; div_val = 8'd4;
        for (int k = 2; k < 17; k++) begin
            step();
            div_wr = 1'b0;
            checks++;
            if (div_ack !== (k == 2) || div_err !== 1'b0) begin
                errors++;
                $display("FAIL write_ack k=%0d: ack=%b err=%b required ack=%b err=0",
                         k, div_ack, div_err, k == 2);
            end
            checks++;
            if (k < 5) begin
                if (clk_out[1] !== ((k % 5) < 3) || tick[1] !== 1'b0) begin
                    errors++;
                    $display("FAIL write_old_period k=%0d: clk=%b tick=%b", k, clk_out[1], tick[1]);
                end
            end else if (clk_out[1] !== (((k - 5) % 4) < 2) || tick[1] !== (((k - 5) % 4) == 0)) begin
                errors++;
                $display("FAIL write_new_d4 k=%0d: clk=%b tick=%b required clk=%b tick=%b",
                         k, clk_out[1], tick[1], ((k - 5) % 4) < 2, ((k - 5) % 4) == 0);
            end
        end
    endtask

    task automatic test_err();
        logic [CNT_W-1:0] vals [3];
        logic [1:0]       sels [3];
        vals[0] = 8'd1; vals[1] = 8'd0; vals[2] = 8'd4;
        sels[0] = 2'd0; sels[1] = 2'd0; sels[2] = 2'd3;
        do_reset();
        en = 3'b001;
        step();
        for (int w = 0; w < 3; w++) begin
            div_wr = 1'b1; div_sel = sels[w]; div_val = vals[w];
            step();
            checks++;
            if (div_err !== 1'b1 || div_ack !== 1'b0) begin
                errors++;
                $display("FAIL err_write%0d: err=%b ack=%b required err=1 ack=0", w, div_err, div_ack);
            end
        end
        div_wr = 1'b0;
        for (int k = 4; k < 14; k++) begin
            step();
            checks++;
            if (div_err !== 1'b0 || clk_out[0] !== ((k % 5) < 3) || tick[0] !== ((k % 5) == 0)) begin
                errors++;
                $display("FAIL err_period_kept k=%0d: err=%b clk=%b tick=%b", k, div_err, clk_out[0], tick[0]);
            end
        end
    endtask

    task automatic test_sync();
        do_reset();
        div_wr = 1'b1; div_sel = 2'd0; div_val = 8'd3;
        step();
        div_sel = 2'd1; div_val = 8'd7;
        step();
        div_wr = 1'b0;
        en = 3'b001;
        step();
        step();
        en = 3'b011;
        step();
        checks++;
        if (tick[1:0] !== 2'b10) begin
            errors++;
            $display("FAIL sync_misaligned: tick=%b required 10", tick[1:0]);
        end
        sync = 1'b1;
        for (int j = 0; j < 22; j++) begin
            step();
            sync = 1'b0;
            checks++;
            if (tick[0] !== ((j % 3) == 0) || tick[1] !== ((j % 7) == 0) || tick[2] !== 1'b0 ||
                clk_out[1] !== ((j % 7) < 4) || clk_out[0] !== ((j % 3) < 2)) begin
                errors++;
                $display("FAIL sync_align j=%0d: tick=%b clk_out=%b", j, tick, clk_out);
            end
        end
    endtask

    task automatic test_last_write();
        do_reset();
        en = 3'b100;
        step();
        step();
        div_wr = 1'b1; div_sel = 2'd2; div_val = 8'd6;
        step();
        div_val = 8'd8;
        step();
        div_wr = 1'b0;
        checks++;
        if (div_ack !== 1'b1) begin
            errors++;
            $display("FAIL last_write_ack: ack=%b required 1", div_ack);
        end
        for (int k = 4; k < 22; k++) begin
            step();
            checks++;
            if (k < 5) begin
                if (clk_out[2] !== 1'b0 || tick[2] !== 1'b0) begin
                    errors++;
                    $display("FAIL last_write_old k=%0d: clk=%b tick=%b", k, clk_out[2], tick[2]);
                end
            end else if (clk_out[2] !== (((k - 5) % 8) < 4) || tick[2] !== (((k - 5) % 8) == 0)) begin
                errors++;
                $display("FAIL last_write_d8 k=%0d: clk=%b tick=%b", k, clk_out[2], tick[2]);
            end
        end
    endtask

    task automatic test_en_fall();
        do_reset();
        en = 3'b001;
        step();
        div_wr = 1'b1; div_sel = 2'd0; div_val = 8'd2;
        step();
        div_wr = 1'b0;
        en = 3'b000;
        step();
        checks++;
        if (clk_out[0] !== 1'b0 || tick[0] !== 1'b0) begin
            errors++;
            $display("FAIL en_fall_stop: clk=%b tick=%b required 0", clk_out[0], tick[0]);
        end
        en = 3'b001;
        for (int j = 0; j < 6; j++) begin
            step();
            checks++;
            if (clk_out[0] !== ((j % 2) == 0) || tick[0] !== ((j % 2) == 0)) begin
                errors++;
                $display("FAIL en_fall_d2 j=%0d: clk=%b tick=%b", j, clk_out[0], tick[0]);
            end
        end
    endtask

    task automatic test_rst_async();
        do_reset();
        en = 3'b001;
        step();
        step();
        div_wr = 1'b1; div_sel = 2'd0; div_val = 8'd3;
        step();
        div_wr = 1'b0;
        checks++;
        if (clk_out[0] !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: clk=%b required 1", clk_out[0]);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (clk_out !== '0 || tick !== '0 || div_ack !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: clk_out=%b tick=%b ack=%b required 0", clk_out, tick, div_ack);
        end
        step();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            checks++;
            if (clk_out[0] !== ((k % 5) < 3) || tick[0] !== ((k % 5) == 0)) begin
                errors++;
                $display("FAIL rst_restart k=%0d: clk=%b tick=%b", k, clk_out[0], tick[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_write();
        test_err();
        test_sync();
        test_last_write();
        test_en_fall();
        test_rst_async();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
